// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: initiator-side controller for a single-port 512x32 RAM with
// synchronous write and registered synchronous read.
// Accepts one load/store at a time over valid/ready, drives registered RAM pins,
// and returns a uniform one-cycle response pulse two cycles after acceptance.
// Optional feature macro: MEM_ACC_RMW_EN -- partial-word stores via
// read-modify-write (req_be honoured, extra RMW_WR state, 3-cycle latency).
module ram_access_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_data_in,
  output logic                  ram_we,
  input  logic [DATA_W-1:0]     ram_data_out
);

`ifdef MEM_ACC_RMW_EN
  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RMW_WR  = 2'd3
  } state_t;

  // Overlay the enabled bytes of the new word onto the word read from the RAM.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] m;
    m = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  // Byte enables have no effect when every store writes the full word.
  logic unused_be;
  assign unused_be = ^req_be;
`endif

  state_t            state_q,       state_d;
  logic              ram_we_q,      ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q,    ram_addr_d;
  logic [DATA_W-1:0] ram_data_in_q, ram_data_in_d;
  logic              rsp_valid_q,   rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic              load_q,        load_d;
`ifdef MEM_ACC_RMW_EN
  logic [BE_W-1:0]   be_q,          be_d;
`endif

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign ram_addr    = ram_addr_q;
  assign ram_data_in = ram_data_in_q;
  assign ram_we      = ram_we_q;

  // Next-state and next-output logic for the request sequencer.
  always_comb begin
    state_d       = state_q;
    ram_we_d      = ram_we_q;
    ram_addr_d    = ram_addr_q;
    ram_data_in_d = ram_data_in_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    load_d        = load_q;
`ifdef MEM_ACC_RMW_EN
    be_d          = be_q;
`endif
    case (state_q)
      ST_IDLE: begin
        ram_we_d = 1'b0;
        if (req_valid) begin
          state_d       = ST_ISSUE;
          ram_addr_d    = req_addr;
          ram_data_in_d = req_wdata;
          ram_we_d      = req_we;
          load_d        = ~req_we;
`ifdef MEM_ACC_RMW_EN
          be_d          = req_be;
          // Empty or partial byte masks never write during ISSUE: empty masks
          // skip the write entirely, partial masks read the old word first.
          if (req_we && (req_be != {BE_W{1'b1}})) ram_we_d = 1'b0;
`endif
        end
      end
      ST_ISSUE: begin
        state_d  = ST_CAPTURE;
        ram_we_d = 1'b0;
      end
      ST_CAPTURE: begin
`ifdef MEM_ACC_RMW_EN
        if (!load_q && (be_q != '0) && (be_q != {BE_W{1'b1}})) begin
          state_d       = ST_RMW_WR;
          ram_we_d      = 1'b1;
          ram_data_in_d = merge_bytes(ram_data_out, ram_data_in_q, be_q);
        end else
`endif
        begin
          state_d     = ST_IDLE;
          ram_we_d    = 1'b0;
          rsp_valid_d = 1'b1;
          if (load_q) rsp_rdata_d = ram_data_out;
        end
      end
`ifdef MEM_ACC_RMW_EN
      ST_RMW_WR: begin
        state_d     = ST_IDLE;
        ram_we_d    = 1'b0;
        rsp_valid_d = 1'b1;
      end
`endif
      default: begin
        state_d  = ST_IDLE;
        ram_we_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; async reset drops any pending transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_data_in_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      load_q        <= 1'b0;
`ifdef MEM_ACC_RMW_EN
      be_q          <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_in_q <= ram_data_in_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      load_q        <= load_d;
`ifdef MEM_ACC_RMW_EN
      be_q          <= be_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed bench for ram_access_ctrl with a behavioural
// 512x32 RAM (sync write, registered read) attached to the ram_* pins.
module tb_ram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [8:0]  ram_addr;
  logic [31:0] ram_data_in;
  logic        ram_we;
  logic [31:0] ram_data_out;

  logic [31:0] mem [512];

  int n_chk = 0;
  int n_err = 0;

  ram_access_ctrl #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_be       (req_be),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_we       (ram_we),
    .ram_data_out (ram_data_out)
  );

  always #5 clk = ~clk;

  // Single-port RAM: synchronous write, registered read (old data on collision).
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data_in;
    ram_data_out <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One transaction from an idle sample point; returns edges from accept to
  // rsp_valid, number of sampled cycles with ram_we high, and the response data.
  task automatic txn(input logic we, input logic [8:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, output int lat, output int wc,
                     output logic [31:0] rd);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    tick;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 9'($urandom);
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    lat = 0;
    wc  = ram_we ? 1 : 0;
    while (!rsp_valid && lat < 8) begin
      tick;
      lat++;
      if (ram_we) wc++;
    end
    rd = rsp_rdata;
  endtask

  logic        v_we   [4];
  logic [8:0]  v_addr [4];
  logic [31:0] v_data [4];
  int          acc_c  [4];
  logic        acc;
  int          k, n_rsp, lat, wc;
  logic [31:0] rd;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    v_we[0] = 1'b1; v_addr[0] = 9'h000; v_data[0] = 32'h0F0F0F0F;
    v_we[1] = 1'b0; v_addr[1] = 9'h000; v_data[1] = 32'h0F0F0F0F;
    v_we[2] = 1'b1; v_addr[2] = 9'h1FF; v_data[2] = 32'hF00DBABE;
    v_we[3] = 1'b0; v_addr[3] = 9'h1FF; v_data[3] = 32'hF00DBABE;

    // 1: reset with random inputs
    rst_n = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = 9'($urandom);
      req_wdata = $urandom; req_be = 4'($urandom);
      tick;
      check("rst_ram_we",      32'(ram_we),      32'd0);
      check("rst_ram_addr",    32'(ram_addr),    32'd0);
      check("rst_ram_data_in", ram_data_in,      32'd0);
      check("rst_rsp_valid",   32'(rsp_valid),   32'd0);
      check("rst_rsp_rdata",   rsp_rdata,        32'd0);
      check("rst_req_ready",   32'(req_ready),   32'd1);
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    tick;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_we",    32'(ram_we),    32'd0);

    // 2: store 0x1A5 <= 0xDEADBEEF, cycle by cycle
    req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h1A5; req_wdata = 32'hDEADBEEF; req_be = 4'hF;
    tick;
    req_valid = 1'b0;
    check("st_issue_we",    32'(ram_we),    32'd1);
    check("st_issue_addr",  32'(ram_addr),  32'h1A5);
    check("st_issue_data",  ram_data_in,    32'hDEADBEEF);
    check("st_issue_ready", 32'(req_ready), 32'd0);
    check("st_issue_rsp",   32'(rsp_valid), 32'd0);
    tick;
    check("st_cap_we",  32'(ram_we),    32'd0);
    check("st_cap_rsp", 32'(rsp_valid), 32'd0);
    tick;
    check("st_rsp_valid", 32'(rsp_valid), 32'd1);
    check("st_rsp_ready", 32'(req_ready), 32'd1);
    check("st_mem",       mem[9'h1A5],    32'hDEADBEEF);
    check("st_rdata_unch", rsp_rdata,     32'd0);
    tick;
    check("st_rsp_pulse", 32'(rsp_valid), 32'd0);

    // 3: load back 0x1A5; data holds after the pulse and through a store
    txn(1'b0, 9'h1A5, 32'h0, 4'hF, lat, wc, rd);
    check("ld_lat",   32'(lat), 32'd2);
    check("ld_we",    32'(wc),  32'd0);
    check("ld_rdata", rd,       32'hDEADBEEF);
    tick;
    check("ld_rsp_pulse", 32'(rsp_valid), 32'd0);
    check("ld_rdata_hold", rsp_rdata, 32'hDEADBEEF);
    txn(1'b1, 9'h0AA, 32'h55AA55AA, 4'hF, lat, wc, rd);
    check("st2_lat", 32'(lat), 32'd2);
    check("st2_we_cycles", 32'(wc), 32'd1);
    check("st2_rdata_unch", rd, 32'hDEADBEEF);

    // 4: req_valid held high, alternating store/load at the address extremes
    k = 0; n_rsp = 0;
    req_valid = 1'b1; req_we = v_we[0]; req_addr = v_addr[0]; req_wdata = v_data[0]; req_be = 4'hF;
    for (int c = 0; c < 14; c++) begin
      acc = req_valid && req_ready;
      tick;
      if (rsp_valid) begin
        n_rsp++;
        if (k > 0 && !v_we[k-1]) check("bb_load_data", rsp_rdata, v_data[k-1]);
      end
      if (acc && k < 4) begin
        acc_c[k] = c;
        k++;
        if (k < 4) begin
          req_we = v_we[k]; req_addr = v_addr[k]; req_wdata = v_data[k];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    check("bb_accepts", 32'(k),     32'd4);
    check("bb_rsps",    32'(n_rsp), 32'd4);
    check("bb_first",   32'(acc_c[0]), 32'd0);
    for (int i = 1; i < 4; i++) check("bb_spacing", 32'(acc_c[i] - acc_c[i-1]), 32'd3);
    check("bb_mem_lo", mem[9'h000], 32'h0F0F0F0F);
    check("bb_mem_hi", mem[9'h1FF], 32'hF00DBABE);

    // 5: reset during ISSUE of a store
    txn(1'b1, 9'h010, 32'h12345678, 4'hF, lat, wc, rd);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h010; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    tick;
    req_valid = 1'b0;
    check("mid_issue_we", 32'(ram_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_we_drop",  32'(ram_we),    32'd0);
    check("mid_rsp",      32'(rsp_valid), 32'd0);
    tick;
    tick;
    rst_n = 1'b1;
    n_rsp = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (rsp_valid) n_rsp++;
    end
    check("mid_no_rsp", 32'(n_rsp), 32'd0);
    txn(1'b0, 9'h010, 32'h0, 4'hF, lat, wc, rd);
    check("mid_old_data", rd, 32'h12345678);

    // 6: partial byte-enable store
    txn(1'b1, 9'h020, 32'h11223344, 4'hF, lat, wc, rd);
    txn(1'b1, 9'h020, 32'hAABBCCDD, 4'b0101, lat, wc, rd);
`ifdef MEM_ACC_RMW_EN
    check("be_lat",  32'(lat), 32'd3);
    check("be_we",   32'(wc),  32'd1);
    check("be_mem",  mem[9'h020], 32'h11BB33DD);
    txn(1'b1, 9'h020, 32'h00000000, 4'b0000, lat, wc, rd);
    check("be0_lat", 32'(lat), 32'd2);
    check("be0_we",  32'(wc),  32'd0);
    check("be0_mem", mem[9'h020], 32'h11BB33DD);
`else
    check("be_lat",  32'(lat), 32'd2);
    check("be_we",   32'(wc),  32'd1);
    check("be_mem",  mem[9'h020], 32'hAABBCCDD);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
